// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - EX-stage branch resolution, bimodal BHT and redirect/flush control
module branch_ctrl #(
  parameter int BHT_DEPTH    = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_br,
  input  logic        i_ex_is_jmp,
  input  logic [2:0]  i_ex_funct3,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  output logic        o_br_un,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush,
  output logic        o_illegal,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_miss_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE,
    S_FLUSH
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       bht_q [BHT_DEPTH];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             br_taken;
  logic             br_illegal;
  logic             resolve;
  logic             do_jmp;
  logic             do_br;
  logic             mispredict;
  logic             redirect_fire;
  logic [31:0]      redirect_target;

  assign if_idx       = i_if_pc[IDX_W+1:2];
  assign ex_idx       = i_ex_pc[IDX_W+1:2];
  // Read port has no bypass: a same-cycle update shows up one cycle later
  assign o_pred_taken = bht_q[if_idx][1];
  assign o_br_un      = i_ex_funct3[1];

  always_comb begin
    br_taken   = 1'b0;
    br_illegal = 1'b0;
    case (i_ex_funct3)
      3'b000:         br_taken = i_br_equal;
      3'b001:         br_taken = !i_br_equal;
      3'b100, 3'b110: br_taken = i_br_less;
      3'b101, 3'b111: br_taken = !i_br_less;
      default:        br_illegal = 1'b1;
    endcase
  end

  // Wrong-path instructions sitting in EX during FLUSH never resolve
  assign resolve       = i_ex_valid & ~i_stall & (state_q == S_IDLE) & (i_ex_is_br | i_ex_is_jmp);
  assign do_jmp        = resolve & i_ex_is_jmp;
  assign do_br         = resolve & ~i_ex_is_jmp & ~br_illegal;
  assign mispredict    = do_br & (br_taken != i_ex_pred_taken);
  assign redirect_fire = do_jmp | mispredict;
  assign redirect_target = (do_jmp | br_taken) ? i_ex_target : i_ex_pc + 32'd4;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (redirect_fire) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_INIT;
        end
      end
      S_FLUSH: begin
        if (!i_stall) begin
          if (cnt_q <= CNT_ONE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_flush = (state_q == S_FLUSH);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      o_redirect    <= 1'b0;
      o_redirect_pc <= '0;
      o_illegal     <= 1'b0;
      o_br_cnt      <= '0;
      o_miss_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      o_redirect <= redirect_fire;
      o_illegal  <= resolve & ~i_ex_is_jmp & br_illegal;
      if (redirect_fire) begin
        o_redirect_pc <= redirect_target;
        o_miss_cnt    <= o_miss_cnt + 32'd1;
      end
      if (do_br) begin
        o_br_cnt <= o_br_cnt + 32'd1;
      end
    end
  end

  // Entries start weakly not-taken and saturate at 00 / 11
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (do_br) begin
      if (br_taken && (bht_q[ex_idx] != 2'b11)) begin
        bht_q[ex_idx] <= bht_q[ex_idx] + 2'd1;
      end else if (!br_taken && (bht_q[ex_idx] != 2'b00)) begin
        bht_q[ex_idx] <= bht_q[ex_idx] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - directed and randomized check of branch_ctrl against a behavioural model
module tb_branch_ctrl;

  localparam int BHT_DEPTH    = 16;
  localparam int FLUSH_CYCLES = 2;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_stall;
  logic [31:0] i_if_pc;
  logic        o_pred_taken;
  logic        i_ex_valid;
  logic        i_ex_is_br;
  logic        i_ex_is_jmp;
  logic [2:0]  i_ex_funct3;
  logic [31:0] i_ex_pc;
  logic [31:0] i_ex_target;
  logic        i_ex_pred_taken;
  logic        o_br_un;
  logic        i_br_less;
  logic        i_br_equal;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic        o_flush;
  logic        o_illegal;
  logic [31:0] o_br_cnt;
  logic [31:0] o_miss_cnt;

  always #5 i_clk = ~i_clk;

  branch_ctrl #(
    .BHT_DEPTH   (BHT_DEPTH),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_stall        (i_stall),
    .i_if_pc        (i_if_pc),
    .o_pred_taken   (o_pred_taken),
    .i_ex_valid     (i_ex_valid),
    .i_ex_is_br     (i_ex_is_br),
    .i_ex_is_jmp    (i_ex_is_jmp),
    .i_ex_funct3    (i_ex_funct3),
    .i_ex_pc        (i_ex_pc),
    .i_ex_target    (i_ex_target),
    .i_ex_pred_taken(i_ex_pred_taken),
    .o_br_un        (o_br_un),
    .i_br_less      (i_br_less),
    .i_br_equal     (i_br_equal),
    .o_redirect     (o_redirect),
    .o_redirect_pc  (o_redirect_pc),
    .o_flush        (o_flush),
    .o_illegal      (o_illegal),
    .o_br_cnt       (o_br_cnt),
    .o_miss_cnt     (o_miss_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Stimulus for the next cycle
  logic        s_reset, s_stall, s_valid, s_is_br, s_is_jmp, s_pred;
  logic [2:0]  s_funct3;
  logic [31:0] s_ex_pc, s_target, s_if_pc, s_rs1, s_rs2;

  // Reference model state
  int          m_bht [BHT_DEPTH];
  int          m_flush_left;
  logic        m_redirect, m_illegal;
  logic [31:0] m_rpc, m_br, m_miss;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % BHT_DEPTH);
  endfunction

  function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BHT_DEPTH; i++) m_bht[i] = 1;
    m_flush_left = 0;
    m_redirect   = 1'b0;
    m_illegal    = 1'b0;
    m_rpc        = '0;
    m_br         = '0;
    m_miss       = '0;
  endtask

  task automatic clear_stim();
    s_reset = 0; s_stall = 0; s_valid = 0; s_is_br = 0; s_is_jmp = 0; s_pred = 0;
    s_funct3 = 3'd0; s_ex_pc = '0; s_target = '0; s_rs1 = '0; s_rs2 = 32'd1;
  endtask

  task automatic do_cycle();
    bit          resolve, taken, n_redirect, n_illegal, unsigned_cmp;
    int          n_flush, idx, upd_idx, upd_val;
    logic [31:0] n_rpc, n_br, n_miss;
    @(negedge i_clk);
    unsigned_cmp    = s_funct3 inside {3'd2, 3'd3, 3'd6, 3'd7};
    i_reset         = s_reset;
    i_stall         = s_stall;
    i_if_pc         = s_if_pc;
    i_ex_valid      = s_valid;
    i_ex_is_br      = s_is_br;
    i_ex_is_jmp     = s_is_jmp;
    i_ex_funct3     = s_funct3;
    i_ex_pc         = s_ex_pc;
    i_ex_target     = s_target;
    i_ex_pred_taken = s_pred;
    i_br_equal      = (s_rs1 == s_rs2);
    i_br_less       = unsigned_cmp ? (s_rs1 < s_rs2) : ($signed(s_rs1) < $signed(s_rs2));
    if (s_reset) model_reset();
    #1;
    check("pred_taken", o_pred_taken, m_bht[idx_of(s_if_pc)] >= 2);
    check("br_un", o_br_un, unsigned_cmp);
    if (s_reset) begin
      check("rst_flush", o_flush, 0);
      check("rst_redirect", o_redirect, 0);
      check("rst_br_cnt", o_br_cnt, 0);
      check("rst_miss_cnt", o_miss_cnt, 0);
    end
    n_redirect = 0; n_illegal = 0; n_flush = m_flush_left;
    n_rpc = m_rpc; n_br = m_br; n_miss = m_miss; upd_idx = -1; upd_val = 0;
    if (!s_reset) begin
      if (m_flush_left > 0 && !s_stall) n_flush = m_flush_left - 1;
      resolve = (m_flush_left == 0) && s_valid && !s_stall && (s_is_br || s_is_jmp);
      if (resolve) begin
        if (s_is_jmp) begin
          n_redirect = 1;
          n_rpc      = s_target;
        end else if (s_funct3 == 3'd2 || s_funct3 == 3'd3) begin
          n_illegal = 1;
        end else begin
          taken   = ref_taken(s_funct3, s_rs1, s_rs2);
          n_br    = m_br + 1;
          idx     = idx_of(s_ex_pc);
          upd_idx = idx;
          upd_val = taken ? ((m_bht[idx] == 3) ? 3 : m_bht[idx] + 1)
                          : ((m_bht[idx] == 0) ? 0 : m_bht[idx] - 1);
          if (taken != s_pred) begin
            n_redirect = 1;
            n_rpc      = taken ? s_target : s_ex_pc + 32'd4;
          end
        end
        if (n_redirect) begin
          n_miss  = m_miss + 1;
          n_flush = FLUSH_CYCLES;
        end
      end
    end
    @(posedge i_clk);
    #1;
    m_redirect = n_redirect; m_illegal = n_illegal; m_flush_left = n_flush;
    m_rpc = n_rpc; m_br = n_br; m_miss = n_miss;
    if (upd_idx >= 0) m_bht[upd_idx] = upd_val;
    check("redirect", o_redirect, m_redirect);
    check("redirect_pc", o_redirect_pc, m_rpc);
    check("flush", o_flush, m_flush_left > 0);
    check("illegal", o_illegal, m_illegal);
    check("br_cnt", o_br_cnt, m_br);
    check("miss_cnt", o_miss_cnt, m_miss);
  endtask

  task automatic set_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                            input logic [31:0] a, input logic [31:0] b, input logic pred);
    clear_stim();
    s_valid = 1; s_is_br = 1; s_funct3 = f3; s_ex_pc = pc; s_target = tgt;
    s_rs1 = a; s_rs2 = b; s_pred = pred;
  endtask

  initial begin
    i_reset = 1; i_stall = 0; i_if_pc = '0; i_ex_valid = 0; i_ex_is_br = 0; i_ex_is_jmp = 0;
    i_ex_funct3 = '0; i_ex_pc = '0; i_ex_target = '0; i_ex_pred_taken = 0;
    i_br_less = 0; i_br_equal = 0;
    model_reset();
    clear_stim();
    s_if_pc = 32'h100;
    s_reset = 1;
    repeat (2) do_cycle();

    // Reset state
    s_reset = 0;
    do_cycle();
    check("t1_pred", o_pred_taken, 0);
    check("t1_br_cnt", o_br_cnt, 0);
    check("t1_flush", o_flush, 0);

    // BEQ taken, predicted not-taken
    s_if_pc = 32'h40;
    set_branch(3'b000, 32'h40, 32'h80, 32'd5, 32'd5, 1'b0);
    do_cycle();
    check("t2_redirect", o_redirect, 1);
    check("t2_redirect_pc", o_redirect_pc, 32'h80);
    check("t2_br_cnt", o_br_cnt, 1);
    check("t2_miss_cnt", o_miss_cnt, 1);
    clear_stim();
    do_cycle();
    check("t2_flush2", o_flush, 1);
    check("t2_pred_0x40", o_pred_taken, 1);
    do_cycle();
    check("t2_flush_done", o_flush, 0);

    // BLTU mode select, then BGE not-taken predicted taken
    set_branch(3'b110, 32'h44, 32'h90, 32'd1, 32'd2, 1'b1);
    s_valid = 0;
    do_cycle();
    check("t3_bltu_un", o_br_un, 1);
    set_branch(3'b101, 32'h44, 32'h90, 32'd1, 32'd2, 1'b1);
    do_cycle();
    check("t3_bge_un", o_br_un, 0);
    check("t3_redirect_pc", o_redirect_pc, 32'h48);
    clear_stim();
    repeat (3) do_cycle();

    // BNE saturates, then a not-taken mispredict
    s_if_pc = 32'h10;
    for (int k = 0; k < 3; k++) begin
      set_branch(3'b001, 32'h10, 32'h400, 32'd1, 32'd2, 1'b1);
      do_cycle();
    end
    check("t4_pred_sat", o_pred_taken, 1);
    set_branch(3'b001, 32'h10, 32'h400, 32'd3, 32'd3, 1'b1);
    do_cycle();
    check("t4_redirect_pc", o_redirect_pc, 32'h14);
    check("t4_pred_after", o_pred_taken, 1);
    clear_stim();
    repeat (3) do_cycle();

    // JAL then a wrong-path branch during FLUSH
    clear_stim();
    s_valid = 1; s_is_jmp = 1; s_ex_pc = 32'h20; s_target = 32'h200;
    do_cycle();
    set_branch(3'b000, 32'h24, 32'h300, 32'd7, 32'd7, 1'b0);
    do_cycle();
    do_cycle();
    check("t5_redirect_pc", o_redirect_pc, 32'h200);
    check("t5_br_cnt", o_br_cnt, 6);
    check("t5_miss_cnt", o_miss_cnt, 4);
    clear_stim();
    repeat (2) do_cycle();

    // Stall mid-FLUSH, then reset mid-FLUSH
    clear_stim();
    s_valid = 1; s_is_jmp = 1; s_ex_pc = 32'h30; s_target = 32'h300;
    do_cycle();
    clear_stim();
    s_stall = 1;
    repeat (3) do_cycle();
    check("t6_flush_stalled", o_flush, 1);
    s_stall = 0;
    do_cycle();
    check("t6_flush_last", o_flush, 1);
    do_cycle();
    check("t6_flush_end", o_flush, 0);
    s_valid = 1; s_is_jmp = 1; s_ex_pc = 32'h34; s_target = 32'h340;
    do_cycle();
    clear_stim();
    s_reset = 1;
    do_cycle();
    s_reset = 0;
    do_cycle();

    // Illegal funct3
    s_if_pc = 32'h50;
    set_branch(3'b010, 32'h50, 32'h500, 32'd1, 32'd2, 1'b1);
    do_cycle();
    check("t6_illegal", o_illegal, 1);
    check("t6_ill_br_cnt", o_br_cnt, 0);
    check("t6_ill_miss_cnt", o_miss_cnt, 0);
    clear_stim();
    do_cycle();
    check("t6_illegal_once", o_illegal, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int kind;
      clear_stim();
      s_reset  = ($urandom % 250) == 0;
      s_stall  = ($urandom % 5) == 0;
      s_valid  = ($urandom % 4) != 0;
      kind     = $urandom % 8;
      s_is_jmp = (kind == 0);
      s_is_br  = (kind >= 1 && kind <= 6);
      s_funct3 = 3'($urandom % 8);
      s_pred   = 1'($urandom % 2);
      s_ex_pc  = (($urandom % 16) == 0) ? 32'hFFFF_FFFC : {23'd0, 7'($urandom % 128), 2'b00};
      s_if_pc  = {23'd0, 7'($urandom % 128), 2'b00};
      s_target = {$urandom} & 32'hFFFF_FFFC;
      s_rs1    = (($urandom % 2) == 0) ? 32'($urandom % 8) : $urandom;
      s_rs2    = (($urandom % 4) == 0) ? s_rs1 : ((($urandom % 2) == 0) ? 32'($urandom % 8) : $urandom);
      do_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
